rcdbpot_seq: RTL and testbench



---
 rtl/rcdbpot_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_rcdbpot_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcdbpot_seq.sv
// Job sequencer around one rounding/clamping divide-by-power-of-two unit: bias add,
// requantize to int8, pack four bytes per word into a small output FIFO.
module rcdbpot_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    input  logic [31:0]      cfg_exponent,
    input  logic [31:0]      cfg_bias,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        exp_q, exp_d;
    logic [31:0]        bias_q, bias_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               s1_valid_q, s1_valid_d;
    logic [31:0]        s1_sum_q, s1_sum_d;
    logic [23:0]        pack_q, pack_d;
    logic [1:0]         pack_cnt_q, pack_cnt_d;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [31:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [31:0]        push_word;
    logic [7:0]         req_byte;

    logic [3:0]         shift;
    logic [31:0]        mask;
    logic [31:0]        rem_bits;
    logic [31:0]        thresh;
    logic signed [31:0] shifted;
    logic signed [31:0] rounded;
    logic [7:0]         clamped;

    logic               unused_exp;
    assign unused_exp = ^exp_q[31:3];

    // Requantizer: shifted magnitude is below 2^27, so the +1 round cannot overflow.
    always_comb begin
        case (exp_q[2:0])
            3'd7:       shift = 4'd9;
            3'd3:       shift = 4'd5;
            3'd1, 3'd5: shift = 4'd7;
            3'd2, 3'd6: shift = 4'd6;
            default:    shift = 4'd8;
        endcase
        mask     = (32'd1 << shift) - 32'd1;
        rem_bits = s1_sum_q & mask;
        thresh   = (mask >> 1) + {31'd0, s1_sum_q[31]};
        shifted  = $signed(s1_sum_q) >>> shift;
        rounded  = shifted + ((rem_bits > thresh) ? 32'sd1 : 32'sd0);
        if (rounded[31]) begin
            clamped = 8'd0;
        end else if (rounded > 32'sd255) begin
            clamped = 8'd255;
        end else begin
            clamped = rounded[7:0];
        end
        req_byte = clamped - 8'd128;
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        bias_d     = bias_q;
        rem_d      = rem_q;
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        push       = 1'b0;
        push_word  = '0;
        done       = 1'b0;
        busy       = (state_q != ST_IDLE);

        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        in_ready  = (state_q == ST_RUN) && (rem_q != '0) &&
                    (count_q <= CNT_W'(FIFO_DEPTH - 2));
        accept    = in_ready && in_valid;
        pop       = (count_q != '0) && out_ready;

        s1_valid_d = accept;
        s1_sum_d   = accept ? (in_data + bias_q) : s1_sum_q;

        if (s1_valid_q) begin
            if (pack_cnt_q == 2'd3) begin
                push       = 1'b1;
                push_word  = {req_byte, pack_q};
                pack_d     = '0;
                pack_cnt_d = 2'd0;
            end else begin
                case (pack_cnt_q)
                    2'd0:    pack_d[7:0]   = req_byte;
                    2'd1:    pack_d[15:8]  = req_byte;
                    default: pack_d[23:16] = req_byte;
                endcase
                pack_cnt_d = pack_cnt_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    exp_d   = cfg_exponent;
                    bias_d  = cfg_bias;
                    rem_d   = cfg_len;
                    state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                // s1 empty with nothing remaining: the last byte already sits in the packer.
                if ((rem_q == '0) && !s1_valid_q) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pack_cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end else if (!fifo_full) begin
                    push       = 1'b1;
                    push_word  = {8'h00, pack_q};
                    pack_d     = '0;
                    pack_cnt_d = 2'd0;
                    state_d    = ST_DONE;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            bias_q     <= '0;
            rem_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            pack_q     <= '0;
            pack_cnt_q <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            bias_q     <= bias_d;
            rem_q      <= rem_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_rcdbpot_seq.sv
// Directed and randomized bench for rcdbpot_seq with an expected-word scoreboard.
module tb_rcdbpot_seq;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic [31:0]      cfg_exponent;
    logic [31:0]      cfg_bias;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;

    always #5 clk = ~clk;

    rcdbpot_seq #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_exponent(cfg_exponent), .cfg_bias(cfg_bias), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int          idx = 0;
    logic [31:0] exp_q[$];
    logic [31:0] stim[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [31:0] acc, input logic [31:0] bias,
                                              input logic [31:0] e);
        logic [31:0] s;
        longint      v, q, r, thr;
        int          sh;
        s = acc + bias;
        case (e[2:0])
            3'd0, 3'd4: sh = 8;
            3'd1, 3'd5: sh = 7;
            3'd2, 3'd6: sh = 6;
            3'd3:       sh = 5;
            default:    sh = 9;
        endcase
        v   = longint'($signed(s));
        q   = v >>> sh;
        r   = v - (q <<< sh);
        thr = ((longint'(1) <<< sh) - 1) / 2 + ((v < 0) ? 1 : 0);
        if (r > thr) q = q + 1;
        if (q < 0) q = 0;
        else if (q > 255) q = 255;
        return 8'(q - 128);
    endfunction

    task automatic model_job(input logic [31:0] e, input logic [31:0] b);
        logic [31:0] w;
        int          k;
        w = '0;
        k = 0;
        foreach (stim[i]) begin
            w = w | (32'(model_byte(stim[i], b, e)) << (8 * k));
            k++;
            if (k == 4) begin
                exp_q.push_back(w);
                w = '0;
                k = 0;
            end
        end
        if (k != 0) exp_q.push_back(w);
    endtask

    // One clock cycle; called at #1 after a rising edge with this cycle's inputs driven.
    task automatic cycle();
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL spurious_word: observed %h expected no word", out_data);
                end
            end else begin
                check("word", out_data, exp_q.pop_front());
            end
        end
        if (done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] e, input logic [31:0] b, input int len);
        int n;
        n = 0;
        while (busy && n < 500) begin
            cycle();
            n++;
        end
        check("idle_before_cfg", 32'(busy), 32'd0);
        idx          = 0;
        cfg_exponent = e;
        cfg_bias     = b;
        cfg_len      = LEN_W'(len);
        cfg_valid    = 1'b1;
        cycle();
        cfg_valid    = 1'b0;
    endtask

    task automatic feed_count(input int n, input bit rnd);
        int acc, guard;
        bit a;
        acc   = 0;
        guard = 0;
        while (acc < n && idx < stim.size() && guard < 3000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? stim[idx] : $urandom;
            a        = in_valid && in_ready;
            cycle();
            if (a) begin
                idx++;
                acc++;
            end
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 3000) check("feed_timeout", 32'(acc), 32'(n));
    endtask

    task automatic feed_cycles(input int n, output int acc);
        bit a;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = (idx < stim.size());
            in_data  = in_valid ? stim[idx] : '0;
            a        = in_valid && in_ready;
            cycle();
            if (a) begin
                idx++;
                acc++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_cnt;
        n     = 0;
        while (done_cnt == start && n < budget) begin
            cycle();
            n++;
        end
        check("done_seen", 32'(done_cnt - start), 32'd1);
        check("done_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int n;
        rdy_mode = 0;
        n = 0;
        while ((out_valid || exp_q.size() != 0) && n < 300) begin
            cycle();
            n++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("fifo_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] v, e, b;
        int          a1, a2, d0, len;

        reset_n = 1'b0; cfg_valid = 1'b0; cfg_exponent = '0; cfg_bias = '0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset_n = 1'b1;
        cycle();

        // Basic requantize, one full word
        stim.delete();
        stim.push_back(32'd0); stim.push_back(32'd100); stim.push_back(32'd8191); stim.push_back(32'hFFFF_FFFB);
        exp_q.push_back(32'h807F8380);
        start_job(32'd3, 32'd0, 4);
        feed_count(4, 1'b0);
        wait_done(100);
        drain();

        // Bias with a partial word flushed
        stim.delete();
        stim.push_back(32'd0); stim.push_back(32'hFFFF_FFC0);
        exp_q.push_back(32'h0000_8081);
        start_job(32'd3, 32'd32, 2);
        feed_count(2, 1'b0);
        wait_done(100);
        drain();

        // Zero-length job
        cfg_exponent = 32'd3; cfg_bias = 32'd0; cfg_len = '0; cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        check("zero_len_done", 32'(done), 32'd1);
        check("zero_len_busy", 32'(busy), 32'd1);
        cycle();
        check("zero_len_done_end", 32'(done), 32'd0);
        check("zero_len_busy_end", 32'(busy), 32'd0);
        check("zero_len_no_word", 32'(out_valid), 32'd0);

        // cfg_valid during RUN is ignored
        stim.delete();
        for (int i = 0; i < 8; i++) begin
            v = $urandom_range(0, 16000);
            stim.push_back(v - 32'd8000);
        end
        model_job(32'd3, 32'd0);
        start_job(32'd3, 32'd0, 8);
        feed_count(3, 1'b0);
        cfg_exponent = 32'd7; cfg_bias = 32'd1000; cfg_len = LEN_W'(2); cfg_valid = 1'b1;
        feed_count(1, 1'b0);
        cfg_valid = 1'b0;
        feed_count(4, 1'b0);
        d0 = done_cnt;
        wait_done(100);
        repeat (5) cycle();
        check("ignored_cfg_one_done", 32'(done_cnt - d0), 32'd1);
        drain();

        // Backpressure: FIFO held full, then released
        stim.delete();
        for (int i = 0; i < 32; i++) begin
            v = $urandom_range(0, 30000);
            stim.push_back(v - 32'd15000);
        end
        model_job(32'd2, 32'd0);
        rdy_mode = 2;
        start_job(32'd2, 32'd0, 32);
        feed_cycles(20, a1);
        feed_cycles(10, a2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_stall_stable", 32'(a2), 32'd0);
        n_cmp++;
        assert (a1 >= 12 && a1 <= 16) else begin
            n_bad++;
            $error("FAIL bp_accepted: observed %0d expected 12..16", a1);
        end
        rdy_mode = 0;
        feed_count(stim.size() - idx, 1'b0);
        wait_done(200);
        drain();

        // Reset mid-job
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back($urandom);
        rdy_mode = 2;
        start_job(32'd1, 32'd0, 16);
        feed_count(5, 1'b0);
        check("pre_reset_word", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        cycle();
        reset_n = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        repeat (3) cycle();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        rdy_mode = 0;
        stim.delete();
        for (int i = 0; i < 6; i++) begin
            v = $urandom_range(0, 4000);
            stim.push_back(v - 32'd2000);
        end
        model_job(32'd6, 32'd5);
        start_job(32'd6, 32'd5, 6);
        feed_count(6, 1'b0);
        wait_done(100);
        drain();

        // Random regression
        for (int j = 0; j < 8; j++) begin
            e   = $urandom;
            b   = $urandom_range(0, 4000);
            b   = b - 32'd2000;
            len = $urandom_range(1, 23);
            stim.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) v = $urandom;
                else begin
                    v = $urandom_range(0, 200000);
                    v = v - 32'd100000;
                end
                stim.push_back(v);
            end
            model_job(e, b);
            rdy_mode = 1;
            start_job(e, b, len);
            feed_count(len, 1'b1);
            wait_done(2000);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
